risc16_boot_loader: RTL and testbench
=====================================

// Module: risc16_boot_loader
// PURPOSE
// - Byte-stream program loader and run controller for risc16_processor.
// - Accepts framed bytes, assembles 16-bit instruction words, writes them into instruction memory.
// - Holds the core in reset until a checksum-verified image is loaded, then releases it.
// - Detects the HALT idiom (BEQ R0,R0,-1 = 16'hC07F) on the core instruction bus.
// PARAMETERS
// - ADDR_W     8      imem word-address width; capacity = 2**ADDR_W words
// - SYNC_BYTE  8'hA5  frame start marker
// - HALT_WORD  16'hC07F  instruction encoding treated as halt
// PORTS
// - clk         in   1       system clock, rising edge
// - rst         in   1       asynchronous active-high reset
// - in_data     in   8       stream byte
// - in_valid    in   1       in_data valid
// - in_ready    out  1       loader can accept a byte
// - imem_we     out  1       imem write strobe, one-cycle pulse
// - imem_addr   out  ADDR_W  imem word address
// - imem_wdata  out  16      imem write word
// - core_instr  in   16      instruction currently fetched by core
// - core_rst_n  out  1       active-low reset to risc16_processor
// - load_done   out  1       image accepted; core running
// - load_err    out  1       length or checksum error (sticky until next sync)
// - halted      out  1       HALT_WORD seen while running (sticky)
// BEHAVIOUR
// - Reset: state=IDLE; in_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, core_rst_n=0, load_done=0, load_err=0, halted=0.
// - Byte accepted on rising clk when in_valid && in_ready; in_ready=1 in every state except RUN.
// - Frame format: SYNC, LEN_HI, LEN_LO, {W_HI, W_LO} x LEN, CSUM.
// - CSUM = 8-bit modulo-256 sum of the data bytes only.
// - FSM states: IDLE, LEN_HI, LEN_LO, D_HI, D_LO, CSUM, RUN, ERR.
// - IDLE: SYNC_BYTE -> LEN_HI; clears load_err, halted, word_cnt, sum. Any other byte is discarded.
// - LEN_HI -> LEN_LO.
// - LEN_LO: if LEN==0 or LEN>2**ADDR_W -> ERR (load_err=1 next cycle); else -> D_HI.
// - D_HI -> D_LO; the byte is latched as the high half of the word.
// - D_LO: cycle after accept: imem_we=1, imem_addr=word_cnt, imem_wdata={hi,lo}; then word_cnt++.
//   Next state: D_HI if words remain, else CSUM.
// - Write latency: exactly 1 cycle after acceptance of the W_LO byte; big-endian word assembly.
// - CSUM: match -> RUN (core_rst_n=1, load_done=1 next cycle); mismatch -> ERR.
// - ERR: core_rst_n=0, load_err=1; only SYNC_BYTE leaves (-> LEN_HI); other bytes discarded.
// - RUN: core_instr==HALT_WORD at a clk edge -> halted=1 next cycle; stays sticky.
// - core_rst_n=0 in every state but RUN; a new frame can only start after rst unless LOADER_REARM_EN.
// - Reset mid-frame: async abort to IDLE, partial image abandoned, core held in reset.
// - imem_addr holds the last written address between writes.
// COUNTER WIDTHS
// - word_cnt: ADDR_W+1 bits, so LEN == 2**ADDR_W (full memory) is legal without wrap.
// CONFIGURATION
// - LOADER_REARM_EN defined:
//   - On halt detection: halted=1, core_rst_n=0, load_done=0, state -> IDLE (all registered together).
//   - The next frame reloads and reruns the core.
// - LOADER_REARM_EN undefined:
//   - Halt only sets halted; core keeps running (spinning on the halt loop).
//   - in_ready stays 0 in RUN until rst.
// TESTING
// - Load: A5 00 03 24 81 25 02 C0 7F 0B
//   -> writes @0=2481, @1=2502, @2=C07F; core_rst_n=1 and load_done=1 one cycle after the 0B byte.
// - Same frame with CSUM 0C -> load_err=1, core_rst_n stays 0, no RUN.
//   A following valid frame recovers to load_done=1.
// - LEN=0000, and LEN=0101 with ADDR_W=8 -> ERR right after LEN_LO; no imem_we pulse.
// - Garbage bytes 00 FF 3C before A5 -> ignored; load completes as in the first test.
// - RUN with core_instr=C07F for 1 cycle -> halted=1 next cycle.
//   - With LOADER_REARM_EN: core_rst_n=0 and in_ready=1 on the same cycle.
//   - Without LOADER_REARM_EN: core_rst_n stays 1.
// - Assert rst after the W_HI byte of word 1 -> IDLE, core_rst_n=0, all flags 0.
//   A subsequent full frame loads from addr 0.

Source files
------------

// File: rtl/risc16_boot_loader_if.sv
// risc16_boot_loader_if: byte-stream, imem write and core-control signals of the loader
interface risc16_boot_loader_if #(parameter int ADDR_W = 8);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;
  logic [15:0]       core_instr;
  logic              core_rst_n;
  logic              load_done;
  logic              load_err;
  logic              halted;
  modport master (
    output in_data, in_valid, core_instr,
    input  in_ready, imem_we, imem_addr, imem_wdata, core_rst_n, load_done, load_err, halted
  );
  modport slave (
    input  in_data, in_valid, core_instr,
    output in_ready, imem_we, imem_addr, imem_wdata, core_rst_n, load_done, load_err, halted
  );
endinterface

// File: rtl/risc16_boot_loader.sv
// risc16_boot_loader: framed byte loader into imem, checksum-gated core release, halt detect
// LOADER_REARM_EN: halt returns the loader to IDLE with the core held in reset, ready to reload
module risc16_boot_loader #(
  parameter int          ADDR_W    = 8,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter logic [15:0] HALT_WORD = 16'hC07F
) (
  input logic                 clk,
  input logic                 rst,
  risc16_boot_loader_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, D_HI, D_LO, CSUM, RUN, ERR} state_t;
  localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};
  state_t            r_state, w_next;
  logic [7:0]        r_len_hi, r_hi, r_sum;
  logic [ADDR_W:0]   r_len, r_word_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_wdata;
  logic              r_we, r_halted;
  logic              w_acc, w_sync, w_halt, w_len_bad, w_last;
  logic [15:0]       w_len;
  assign w_acc     = bus.in_valid && bus.in_ready;
  assign w_sync    = w_acc && bus.in_data == SYNC_BYTE;
  assign w_halt    = r_state == RUN && bus.core_instr == HALT_WORD;
  assign w_len     = {r_len_hi, bus.in_data};
  assign w_len_bad = w_len == '0 || 32'(w_len) > (32'd1 << ADDR_W);
  assign w_last    = r_word_cnt + ONE == r_len;
  assign bus.in_ready   = r_state != RUN;
  assign bus.core_rst_n = r_state == RUN;
  assign bus.load_done  = r_state == RUN;
  assign bus.load_err   = r_state == ERR;
  assign bus.halted     = r_halted;
  assign bus.imem_we    = r_we;
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = r_wdata;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:   w_next = w_sync ? LEN_HI : IDLE;
      LEN_HI: w_next = w_acc ? LEN_LO : LEN_HI;
      LEN_LO: w_next = !w_acc ? LEN_LO : w_len_bad ? ERR : D_HI;
      D_HI:   w_next = w_acc ? D_LO : D_HI;
      D_LO:   w_next = !w_acc ? D_LO : w_last ? CSUM : D_HI;
      CSUM:   w_next = !w_acc ? CSUM : bus.in_data == r_sum ? RUN : ERR;
`ifdef LOADER_REARM_EN
      RUN:    w_next = w_halt ? IDLE : RUN;
`else
      RUN:    w_next = RUN;
`endif
      ERR:    w_next = w_sync ? LEN_HI : ERR;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_len_hi   <= '0;
      r_hi       <= '0;
      r_sum      <= '0;
      r_len      <= '0;
      r_word_cnt <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (w_halt) r_halted <= 1'b1;
      if (w_sync && (r_state == IDLE || r_state == ERR)) begin
        r_halted   <= 1'b0;
        r_word_cnt <= '0;
        r_sum      <= '0;
      end
      if (w_acc && r_state == LEN_HI) r_len_hi <= bus.in_data;
      if (w_acc && r_state == LEN_LO) r_len <= w_len[ADDR_W:0];
      if (w_acc && r_state == D_HI) begin
        r_hi  <= bus.in_data;
        r_sum <= r_sum + bus.in_data;
      end
      // big-endian word, written the cycle after its low byte
      if (w_acc && r_state == D_LO) begin
        r_we       <= 1'b1;
        r_addr     <= r_word_cnt[ADDR_W-1:0];
        r_wdata    <= {r_hi, bus.in_data};
        r_word_cnt <= r_word_cnt + ONE;
        r_sum      <= r_sum + bus.in_data;
      end
    end
endmodule

// File: tb/tb_risc16_boot_loader.sv
// tb_risc16_boot_loader: vector table, frame corner cases and randomized frames vs a frame-level model
module tb_risc16_boot_loader;
`ifdef LOADER_REARM_EN
  localparam bit REARM = 1'b1;
`else
  localparam bit REARM = 1'b0;
`endif
  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic v; logic [7:0] d; logic [15:0] ci;
    logic we; logic [7:0] a; logic [15:0] wd; logic [4:0] fl;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_bad = 0;
  logic [23:0] got[$];
  logic [15:0] none[$];
  vec_t tv[$];
  risc16_boot_loader_if #(.ADDR_W(8)) bus ();
  risc16_boot_loader dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.imem_we) got.push_back({bus.imem_addr, bus.imem_wdata});
  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  function automatic vec_t mk(logic v, logic [7:0] d, logic [15:0] ci, logic we, logic [7:0] a,
                              logic [15:0] wd, logic [4:0] fl);
    return '{v: v, d: d, ci: ci, we: we, a: a, wd: wd, fl: fl};
  endfunction
  // flags packed as {in_ready, core_rst_n, load_done, load_err, halted}
  function automatic logic [4:0] flags();
    return {bus.in_ready, bus.core_rst_n, bus.load_done, bus.load_err, bus.halted};
  endfunction
  function automatic logic [31:0] outs();
    return {2'b00, bus.imem_we, bus.imem_addr, bus.imem_wdata, flags()};
  endfunction
  function automatic bq_t frame(input logic [15:0] w[$], input int len, input logic [7:0] delta);
    bq_t b;
    logic [7:0] s = 8'h00;
    b.push_back(8'hA5);
    b.push_back(8'(len >> 8));
    b.push_back(8'(len));
    foreach (w[k]) begin
      b.push_back(w[k][15:8]);
      b.push_back(w[k][7:0]);
      s = s + w[k][15:8] + w[k][7:0];
    end
    b.push_back(s + delta);
    return b;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    int n = 0;
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
    end
    @(negedge clk);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready wait", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask
  task automatic send_all(input bq_t b);
    foreach (b[k]) send(b[k]);
  endtask
  task automatic chk_writes(input logic [15:0] w[$]);
    chk("write count", 32'(got.size()), 32'(w.size()));
    for (int i = 0; i < got.size() && i < w.size(); i++)
      chk($sformatf("write %0d", i), 32'(got[i]), {8'h00, i[7:0], w[i]});
    got.delete();
  endtask
  task automatic do_reset();
    #2 rst = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    got.delete();
  endtask
  initial begin
    logic [15:0] ws0[$];
    logic [15:0] w[$];
    bq_t b;
    logic [7:0] g;
    int len, r;
    bit bad, prev_good;
    ws0 = '{16'h2481, 16'h2502, 16'hC07F};
    bus.in_data = 8'h00;
    bus.in_valid = 1'b0;
    bus.core_instr = 16'h0000;
    tv.push_back(mk(1, 8'hA5, 0, 0, 8'h00, 16'h0000, 5'b10000));
    tv.push_back(mk(1, 8'h00, 0, 0, 8'h00, 16'h0000, 5'b10000));
    tv.push_back(mk(1, 8'h03, 0, 0, 8'h00, 16'h0000, 5'b10000));
    tv.push_back(mk(1, 8'h24, 0, 0, 8'h00, 16'h0000, 5'b10000));
    tv.push_back(mk(1, 8'h81, 0, 1, 8'h00, 16'h2481, 5'b10000));
    tv.push_back(mk(1, 8'h25, 0, 0, 8'h00, 16'h2481, 5'b10000));
    tv.push_back(mk(1, 8'h02, 0, 1, 8'h01, 16'h2502, 5'b10000));
    tv.push_back(mk(1, 8'hC0, 0, 0, 8'h01, 16'h2502, 5'b10000));
    tv.push_back(mk(1, 8'h7F, 0, 1, 8'h02, 16'hC07F, 5'b10000));
    tv.push_back(mk(1, 8'h0B, 0, 0, 8'h02, 16'hC07F, 5'b01100));
    tv.push_back(mk(0, 8'h00, 0, 0, 8'h02, 16'hC07F, 5'b01100));
    tv.push_back(mk(1, 8'hA5, 0, 0, 8'h02, 16'hC07F, 5'b01100));
    tv.push_back(mk(0, 8'h00, 16'hC07F, 0, 8'h02, 16'hC07F, REARM ? 5'b10001 : 5'b01101));
    tv.push_back(mk(0, 8'h00, 16'h0000, 0, 8'h02, 16'hC07F, REARM ? 5'b10001 : 5'b01101));
    #3 chk("reset state", outs(), {2'b00, 1'b0, 8'h00, 16'h0000, 5'b10000});
    @(negedge clk);
    rst = 1'b0;
    foreach (tv[i]) begin
      @(negedge clk);
      bus.in_valid   = tv[i].v;
      bus.in_data    = tv[i].d;
      bus.core_instr = tv[i].ci;
      @(posedge clk);
      #1 chk($sformatf("vec %0d", i), outs(), {2'b00, tv[i].we, tv[i].a, tv[i].wd, tv[i].fl});
    end
    bus.in_valid = 1'b0;
    bus.core_instr = 16'h0000;
    do_reset();
    send_all(frame(ws0, 3, 8'h01));
    chk("bad csum flags", 32'(flags()), 32'(5'b10010));
    repeat (3) @(negedge clk);
    chk("bad csum held", 32'(flags()), 32'(5'b10010));
    got.delete();
    send_all(frame(ws0, 3, 8'h00));
    chk("recover flags", 32'(flags()), 32'(5'b01100));
    chk_writes(ws0);
    do_reset();
    send_all('{8'hA5, 8'h00, 8'h00});
    chk("len 0 err", 32'(flags()), 32'(5'b10010));
    send_all('{8'hA5, 8'h01});
    chk("sync leaves err", 32'(flags()), 32'(5'b10000));
    send(8'h01);
    chk("len 257 err", 32'(flags()), 32'(5'b10010));
    repeat (2) @(negedge clk);
    chk_writes(none);
    do_reset();
    send_all('{8'h00, 8'hFF, 8'h3C});
    chk("garbage idle", 32'(flags()), 32'(5'b10000));
    send_all(frame(ws0, 3, 8'h00));
    chk("garbage then load", 32'(flags()), 32'(5'b01100));
    chk_writes(ws0);
    do_reset();
    send_all('{8'hA5, 8'h00, 8'h03, 8'h24, 8'h81, 8'h25});
    #2 rst = 1'b1;
    #1 chk("midframe reset", outs(), {2'b00, 1'b0, 8'h00, 16'h0000, 5'b10000});
    @(negedge clk);
    rst = 1'b0;
    got.delete();
    send_all(frame(ws0, 3, 8'h00));
    chk("reload after reset", 32'(flags()), 32'(5'b01100));
    chk_writes(ws0);
    prev_good = 1'b1;
    for (int it = 0; it < 30; it++) begin
      w.delete();
      r   = $urandom_range(0, 9);
      len = it == 0 ? 256 : r == 0 ? 0 : r == 1 ? $urandom_range(257, 65535) : $urandom_range(1, 6);
      bad = it != 0 && $urandom_range(0, 3) == 0;
      for (int k = 0; k < len && len <= 256; k++) w.push_back(16'($urandom));
      if (prev_good || $urandom_range(0, 1) == 1) do_reset();
      repeat ($urandom_range(0, 3)) begin
        g = 8'($urandom);
        send(g == 8'hA5 ? 8'h5A : g);
      end
      if (len == 0 || len > 256) begin
        send_all('{8'hA5, 8'(len >> 8), 8'(len)});
        chk($sformatf("rnd %0d len err", it), 32'(flags()), 32'(5'b10010));
        @(negedge clk);
        chk_writes(none);
        prev_good = 1'b0;
      end else begin
        send_all(frame(w, len, bad ? 8'($urandom_range(1, 255)) : 8'h00));
        chk($sformatf("rnd %0d flags", it), 32'(flags()), bad ? 32'(5'b10010) : 32'(5'b01100));
        chk_writes(w);
        prev_good = !bad;
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
